// File: rtl/m_mux_arb_nin1out_if.sv
// Flit bus between the input lanes, the output-port mux and the link.
// The mux side uses the slave modport.
interface m_mux_arb_nin1out_if #(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_NUM_IN     = 4,
  parameter int P_SEL_WIDTH  = 2
);
  logic [P_NUM_IN-1:0]              in_valid;
  logic [P_NUM_IN*P_DATA_WIDTH-1:0] in_data;
  logic [P_NUM_IN-1:0]              in_last;
  logic [P_NUM_IN-1:0]              in_ready;
  logic                             out_valid;
  logic [P_DATA_WIDTH-1:0]          out_data;
  logic                             out_last;
  logic [P_SEL_WIDTH-1:0]           out_sel;
  logic                             out_ready;
  logic                             locked;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last,
    input  out_sel, locked
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last,
    output out_sel, locked
  );
endinterface

// File: rtl/m_mux_arb_nin1out.sv
// N-input flit mux with packet-locked round-robin arbitration
// and a registered, back-pressured output stage.
module m_mux_arb_nin1out #(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_NUM_IN     = 4,
  parameter int P_SEL_WIDTH  = 2
) (
  input logic clk,
  input logic reset,
  m_mux_arb_nin1out_if.slave bus
);

  typedef enum logic {IDLE, LOCK} state_e;

  localparam int SW = P_SEL_WIDTH;
  localparam int DW = P_DATA_WIDTH;

  state_e          state_q, state_d;
  logic [SW-1:0]   rr_q, rr_d;
  logic [SW-1:0]   lk_q, lk_d;
  logic            out_valid_q, out_valid_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic            out_last_q, out_last_d;
  logic [SW-1:0]   out_sel_q, out_sel_d;

  logic [SW:0]     cand;
  logic [SW-1:0]   win;
  logic            found;
  logic [SW-1:0]   sel_idx;
  logic            can_load;
  logic [P_NUM_IN-1:0] ready;
  logic            in_xfer;
  logic            x_last;
  logic [DW-1:0]   x_data;

  // First valid input strictly after rr_q, wrapping around.
  always_comb begin
    cand  = '0;
    win   = '0;
    found = 1'b0;
    for (int k = 1; k <= P_NUM_IN; k++) begin
      cand = {1'b0, rr_q} + (SW+1)'(k);
      if (cand >= (SW+1)'(P_NUM_IN))
        cand = cand - (SW+1)'(P_NUM_IN);
      if (!found && bus.in_valid[cand[SW-1:0]]) begin
        found = 1'b1;
        win   = cand[SW-1:0];
      end
    end
  end

  always_comb begin
    sel_idx  = (state_q == LOCK) ? lk_q : win;
    can_load = !out_valid_q || bus.out_ready;
    ready    = '0;
    if (state_q == LOCK || found)
      ready[sel_idx] = can_load;
    in_xfer  = |(bus.in_valid & ready);
    x_last   = bus.in_last[sel_idx];
    x_data   = '0;
    for (int i = 0; i < P_NUM_IN; i++)
      if (sel_idx == SW'(i))
        x_data = bus.in_data[i*DW +: DW];
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    lk_d        = lk_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;
    unique case (state_q)
      IDLE: begin
        if (in_xfer && !x_last) begin
          state_d = LOCK;
          lk_d    = win;
        end else if (in_xfer) begin
          rr_d = win;
        end
      end
      LOCK: begin
        if (in_xfer && x_last) begin
          state_d = IDLE;
          rr_d    = lk_q;
        end
      end
      default: state_d = IDLE;
    endcase
    if (in_xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = x_data;
      out_last_d  = x_last;
      out_sel_d   = sel_idx;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_q        <= SW'(P_NUM_IN-1);
      lk_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      lk_q        <= lk_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.locked    = (state_q == LOCK);

endmodule

// File: tb/tb_m_mux_arb_nin1out.sv
// Bench for the output-port flit mux: per-cycle model compare
// plus directed scenarios with literal expectations.
module tb_m_mux_arb_nin1out;

  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;

  m_mux_arb_nin1out_if #(.P_DATA_WIDTH(W), .P_NUM_IN(N),
    .P_SEL_WIDTH(2)) bus ();

  m_mux_arb_nin1out #(.P_DATA_WIDTH(W), .P_NUM_IN(N),
    .P_SEL_WIDTH(2)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  // Model: who owns the link (-1 = nobody), last packet winner,
  // and what the output register must hold.
  int   m_owner;
  int   m_rr;
  bit   m_ov;
  int   m_od;
  bit   m_ol;
  int   m_os;

  task automatic m_reset();
    m_owner = -1;
    m_rr    = N - 1;
    m_ov    = 0;
    m_od    = 0;
    m_ol    = 0;
    m_os    = 0;
  endtask

  function automatic logic [N-1:0] m_ready();
    logic [N-1:0] r;
    bit can;
    bit got;
    int c;
    r   = '0;
    got = 0;
    can = !m_ov || bus.out_ready;
    if (m_owner >= 0) begin
      r[m_owner] = can;
    end else begin
      for (int k = 1; k <= N; k++) begin
        c = (m_rr + k) % N;
        if (!got && bus.in_valid[c]) begin
          r[c] = can;
          got  = 1;
        end
      end
    end
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    logic [N-1:0] xf;
    if (reset) begin
      m_reset();
    end else begin
      xf = bus.in_valid & m_ready();
      if (xf != '0) begin
        for (int i = 0; i < N; i++) begin
          if (xf[i]) begin
            m_ov = 1;
            m_od = int'(bus.in_data[i*W +: W]);
            m_ol = bus.in_last[i];
            m_os = i;
            if (bus.in_last[i]) begin
              m_owner = -1;
              m_rr    = i;
            end else begin
              m_owner = i;
            end
          end
        end
      end else if (m_ov && bus.out_ready) begin
        m_ov = 0;
      end
    end
  end

  always @(negedge clk) begin
    check("mdl_in_ready", bus.in_ready, m_ready());
    check("mdl_out_valid", bus.out_valid, m_ov);
    check("mdl_locked", bus.locked, m_owner >= 0);
    check("mdl_out_data", bus.out_data, m_od);
    check("mdl_out_last", bus.out_last, m_ol);
    check("mdl_out_sel", bus.out_sel, m_os);
  end

  int log_q[$];
  always @(negedge clk)
    if (!reset && bus.out_valid && bus.out_ready)
      log_q.push_back(int'(bus.out_sel) * 256 + int'(bus.out_data));

  logic [8:0] src [N][$];
  bit en [N];
  logic [N-1:0] acc;

  task automatic apply();
    logic [N-1:0]   v;
    logic [N*W-1:0] d;
    logic [N-1:0]   l;
    v = '0; d = '0; l = '0;
    for (int i = 0; i < N; i++) begin
      if (en[i] && src[i].size() > 0) begin
        v[i]       = 1'b1;
        d[i*W +: W] = src[i][0][7:0];
        l[i]       = src[i][0][8];
      end
    end
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_last  = l;
  endtask

  task automatic cyc();
    @(negedge clk);
    acc = bus.in_valid & bus.in_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (acc[i]) void'(src[i].pop_front());
    apply();
  endtask

  task automatic drain();
    repeat (2) cyc();
  endtask

  task automatic check_log(input string nm, input int exp[$]);
    check({nm, "_len"}, log_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < log_q.size(); i++)
      check(nm, log_q[i], exp[i]);
    log_q.delete();
  endtask

  initial begin
    for (int i = 0; i < N; i++) en[i] = 1;
    bus.out_ready = 1'b1;
    apply();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_locked", bus.locked, 0);
    check("rst_out_sel", bus.out_sel, 0);
    reset = 1'b0;

    // 1: single-flit packet from input 2
    src[2].push_back({1'b1, 8'hA5});
    apply();
    #1 check("t1_in_ready", bus.in_ready, 4'b0100);
    cyc();
    check("t1_valid", bus.out_valid, 1);
    check("t1_data", bus.out_data, 8'hA5);
    check("t1_sel", bus.out_sel, 2);
    check("t1_last", bus.out_last, 1);
    check("t1_locked", bus.locked, 0);
    drain();
    log_q.delete();

    // 2: 3-flit packet on input 1, input 3 waiting
    src[1].push_back({1'b0, 8'h11});
    src[1].push_back({1'b0, 8'h12});
    src[1].push_back({1'b1, 8'h13});
    apply();
    #1 check("t2_head_rdy", bus.in_ready, 4'b0010);
    cyc();
    src[3].push_back({1'b1, 8'h31});
    apply();
    #1;
    check("t2_locked", bus.locked, 1);
    check("t2_d0", bus.out_data, 8'h11);
    check("t2_rdy_lock", bus.in_ready, 4'b0010);
    cyc();
    check("t2_d1", bus.out_data, 8'h12);
    cyc();
    check("t2_d2", bus.out_data, 8'h13);
    check("t2_tail_last", bus.out_last, 1);
    check("t2_unlocked", bus.locked, 0);
    check("t2_rdy3", bus.in_ready, 4'b1000);
    cyc();
    check("t2_sel3", bus.out_sel, 3);
    drain();
    check_log("t2_log", '{'h111, 'h112, 'h113, 'h331});

    // 3: all inputs offer single-flit packets
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++)
        src[i].push_back({1'b1, 8'(i*16 + k)});
    apply();
    for (int n = 0; n < 8; n++) begin
      cyc();
      check("t3_valid", bus.out_valid, 1);
      check("t3_sel", bus.out_sel, n % 4);
    end
    drain();
    check_log("t3_log", '{'h000, 'h110, 'h220, 'h330,
                          'h001, 'h111, 'h221, 'h331});

    // 4: back-pressure mid-packet
    src[0].push_back({1'b0, 8'h41});
    src[0].push_back({1'b0, 8'h42});
    src[0].push_back({1'b0, 8'h43});
    src[0].push_back({1'b1, 8'h44});
    apply();
    cyc();
    cyc();
    bus.out_ready = 1'b0;
    #1 check("t4_stall_rdy", bus.in_ready, 4'b0000);
    repeat (3) begin
      cyc();
      check("t4_hold", bus.out_data, 8'h42);
      check("t4_hold_rdy", bus.in_ready, 4'b0000);
      check("t4_hold_lock", bus.locked, 1);
    end
    bus.out_ready = 1'b1;
    repeat (3) cyc();
    drain();
    check_log("t4_log", '{'h041, 'h042, 'h043, 'h044});

    // 5: bubble inside a locked packet
    src[0].push_back({1'b0, 8'h51});
    src[0].push_back({1'b0, 8'h52});
    src[0].push_back({1'b1, 8'h53});
    apply();
    cyc();
    en[0] = 0;
    src[1].push_back({1'b1, 8'h61});
    apply();
    repeat (2) begin
      #1;
      check("t5_locked", bus.locked, 1);
      check("t5_no_rdy1", bus.in_ready[1], 0);
      cyc();
    end
    en[0] = 1;
    apply();
    repeat (3) cyc();
    drain();
    check_log("t5_log", '{'h051, 'h052, 'h053, 'h161});

    // 6: asynchronous reset mid-packet
    src[2].push_back({1'b0, 8'h71});
    src[2].push_back({1'b0, 8'h72});
    src[2].push_back({1'b1, 8'h73});
    apply();
    cyc();
    cyc();
    check("t6_pre_lock", bus.locked, 1);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_valid", bus.out_valid, 0);
    check("t6_rst_locked", bus.locked, 0);
    for (int i = 0; i < N; i++) src[i].delete();
    apply();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    log_q.delete();
    src[1].push_back({1'b1, 8'h81});
    src[0].push_back({1'b1, 8'h91});
    apply();
    #1 check("t6_rdy0", bus.in_ready, 4'b0001);
    cyc();
    check("t6_sel0", bus.out_sel, 0);
    check("t6_data0", bus.out_data, 8'h91);
    cyc();
    check("t6_sel1", bus.out_sel, 1);
    drain();
    check_log("t6_log", '{'h091, 'h181});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
